psram_burst_scheduler: RTL

- Sequences and shares the single pSRAM user command channel between the frame uploader (write bursts) and the frame downloader (read bursts).
- Issues one-cycle cmd/cmd_en/addr pulses and counts burst beats.
- Enforces the controller's minimum command-to-command gap.
- Arbitrates round-robin, with a read-urgency override driven by the store queue level.

---
 rtl/camera_control_pkg.sv | 9 +
 rtl/sched_rr_pick.sv | 23 ++
 rtl/psram_burst_scheduler.sv | 123 ++++++++++++
 3 files changed

// File: rtl/camera_control_pkg.sv
// camera_control_pkg: shared scheduler states, requester indices and burst sizing helper
package camera_control_pkg;
  typedef enum logic [1:0] {IDLE, WR_BURST, RD_WAIT, GAP} SchedStates;
  localparam bit WR_IDX = 1'b0;
  localparam bit RD_IDX = 1'b1;
  function automatic int burst_beats(input int memory_burst);
    return memory_burst / 4;
  endfunction
endpackage

// File: rtl/sched_rr_pick.sv
// sched_rr_pick: two-requester round-robin picker with read-urgency override
module sched_rr_pick
  import camera_control_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic wr_rq,
  input  logic rd_rq,
  input  logic rd_urgent,
  input  logic take,
  output logic valid,
  output logic pick_rd,
  output logic urgent_win
);
  logic last_grant;
  assign valid = wr_rq | rd_rq;
  assign pick_rd = rd_rq & (rd_urgent | ~wr_rq | (last_grant == WR_IDX));
  // plain round-robin would have picked the write here
  assign urgent_win = rd_rq & wr_rq & rd_urgent & (last_grant == RD_IDX);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) last_grant <= RD_IDX;
    else if (take) last_grant <= pick_rd ? RD_IDX : WR_IDX;
endmodule

// File: rtl/psram_burst_scheduler.sv
// psram_burst_scheduler: shares the pSRAM command channel between write and read bursts
// Optional burst/urgency statistics outputs under PSRAM_SCHED_STATS_EN.
module psram_burst_scheduler
  import camera_control_pkg::*;
#(
  parameter int BURST_BEATS = burst_beats(32),
  parameter int CMD_GAP     = 15,
  parameter int RD_TIMEOUT  = 64,
  parameter int ADDR_W      = 21
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              init_done,
  input  logic              wr_rq,
  input  logic [ADDR_W-1:0] wr_addr,
  output logic              wr_ack,
  output logic              wr_done,
  input  logic              rd_rq,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_urgent,
  input  logic              rd_data_valid,
  output logic              rd_done,
  output logic              cmd,
  output logic              cmd_en,
  output logic [ADDR_W-1:0] addr,
  output logic              error,
  output logic              busy
`ifdef PSRAM_SCHED_STATS_EN
  ,
  output logic [15:0]       stat_wr_bursts,
  output logic [15:0]       stat_rd_bursts,
  output logic [15:0]       stat_urgent_wins
`endif
);
  localparam int BW = $clog2(BURST_BEATS + 1);
  localparam int TW = $clog2(RD_TIMEOUT + 1);
  localparam int GW = $clog2(CMD_GAP + 1);
  SchedStates state;
  logic [BW-1:0] beat_cnt;
  logic [TW-1:0] to_cnt;
  logic [GW-1:0] gap_cnt;
  logic take, pick_valid, pick_rd, urgent_win;
  assign take = (state == IDLE) && init_done && pick_valid;
  assign busy = state != IDLE;
  sched_rr_pick u_pick (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_rq      (wr_rq),
    .rd_rq      (rd_rq),
    .rd_urgent  (rd_urgent),
    .take       (take),
    .valid      (pick_valid),
    .pick_rd    (pick_rd),
    .urgent_win (urgent_win)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state    <= IDLE;
      beat_cnt <= '0;
      to_cnt   <= '0;
      gap_cnt  <= '0;
      cmd      <= 1'b0;
      cmd_en   <= 1'b0;
      addr     <= '0;
      wr_ack   <= 1'b0;
      wr_done  <= 1'b0;
      rd_done  <= 1'b0;
      error    <= 1'b0;
    end else begin
      cmd     <= 1'b0;
      cmd_en  <= 1'b0;
      addr    <= '0;
      wr_done <= 1'b0;
      rd_done <= 1'b0;
      case (state)
        IDLE: if (take) begin
          cmd      <= ~pick_rd;
          cmd_en   <= 1'b1;
          addr     <= pick_rd ? rd_addr : wr_addr;
          wr_ack   <= ~pick_rd;
          beat_cnt <= pick_rd ? '0 : BW'(1);
          to_cnt   <= '0;
          state    <= pick_rd ? RD_WAIT : WR_BURST;
        end
        // beat_cnt holds the number of wr_ack cycles already issued
        WR_BURST: if (beat_cnt == BW'(BURST_BEATS)) begin
          wr_ack  <= 1'b0;
          wr_done <= 1'b1;
          gap_cnt <= '0;
          state   <= GAP;
        end else beat_cnt <= beat_cnt + 1'b1;
        RD_WAIT: begin
          to_cnt <= to_cnt + 1'b1;
          if (rd_data_valid) beat_cnt <= beat_cnt + 1'b1;
          if (rd_data_valid && beat_cnt == BW'(BURST_BEATS - 1)) begin
            rd_done <= 1'b1;
            gap_cnt <= '0;
            state   <= GAP;
          end else if (to_cnt == TW'(RD_TIMEOUT - 1)) begin
            error   <= 1'b1;
            rd_done <= 1'b1;
            gap_cnt <= '0;
            state   <= GAP;
          end
        end
        GAP: if (gap_cnt == GW'(CMD_GAP - 1)) state <= IDLE;
             else gap_cnt <= gap_cnt + 1'b1;
        default: state <= IDLE;
      endcase
    end
`ifdef PSRAM_SCHED_STATS_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      stat_wr_bursts   <= '0;
      stat_rd_bursts   <= '0;
      stat_urgent_wins <= '0;
    end else begin
      if (wr_done && stat_wr_bursts != 16'hFFFF) stat_wr_bursts <= stat_wr_bursts + 1'b1;
      if (rd_done && stat_rd_bursts != 16'hFFFF) stat_rd_bursts <= stat_rd_bursts + 1'b1;
      if (take && urgent_win && stat_urgent_wins != 16'hFFFF) stat_urgent_wins <= stat_urgent_wins + 1'b1;
    end
`endif
endmodule
